tpi_bus_sync: RTL and testbench



---
 rtl/tpi_pkg.sv | 19 +
 rtl/tpi_post_fifo.sv | 50 +++++
 rtl/tpi_bus_sync.sv | 150 +++++++++++++++
 tb/tb_tpi_bus_sync.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tpi_pkg.sv
// Shared types and constants for the 1551 paddle 6523-style bus front-end.
package tpi_pkg;

  typedef enum logic [1:0] {ARM, IDLE, ACCESS, COMMIT} tpi_state_e;

  localparam logic [2:0] PRA    = 3'd0;
  localparam logic [2:0] PRB    = 3'd1;
  localparam logic [2:0] PRC    = 3'd2;
  localparam logic [2:0] DDRA   = 3'd3;
  localparam logic [2:0] DDRB   = 3'd4;
  localparam logic [2:0] DDRC   = 3'd5;
  localparam logic [2:0] RS_MAX = 3'd5;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } tpi_wr_t;

endpackage

// File: rtl/tpi_post_fifo.sv
// Posted-write buffer: DEPTH-entry FIFO, push while full is accepted only alongside a pop.
module tpi_post_fifo
  import tpi_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    _reset,
  input  logic    push_i,
  input  tpi_wr_t din_i,
  input  logic    pop_i,
  output tpi_wr_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int AW = $clog2(DEPTH);

  tpi_wr_t         mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [AW:0]     cnt_q;
  logic            do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = empty_o ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= din_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/tpi_bus_sync.sv
// Host bus strobe synchroniser and posted-write generator for the 6523-style register file.
// Optional _cs deglitcher enabled by defining TPI_BUS_FILTER_EN.
module tpi_bus_sync
  import tpi_pkg::*;
#(
  parameter int DEPTH       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       _reset,
  input  logic       _cs,
  input  logic       _write,
  input  logic [2:0] rs,
  input  logic [7:0] data_in,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic [2:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_active,
  output logic [2:0] rd_addr,
  output logic       overrun,
  output logic       bad_addr,
  input  logic       ovr_clr
);

  localparam int SW   = 13;
  // Sync/filter registers reset to "idle"; hold ARM until real samples have flushed through.
  localparam int WARM = SYNC_STAGES + FILTER_LEN + 1;
  localparam int WW   = $clog2(WARM + 1);

  logic [SYNC_STAGES-1:0][SW-1:0] sync_q;
  logic       cs_s, we_s, cs_f;
  logic [2:0] rs_s;
  logic [7:0] d_s;

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) sync_q <= '1;
    else begin
      sync_q[0] <= {_cs, _write, rs, data_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {cs_s, we_s, rs_s, d_s} = sync_q[SYNC_STAGES-1];

`ifdef TPI_BUS_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN) + 1;
  logic          flt_q, flip;
  logic [FW-1:0] fcnt_q;

  // Output flips combinationally on the FILTER_LEN-th matching sample.
  assign flip = (cs_s != flt_q) && (fcnt_q == FW'(FILTER_LEN - 1));
  assign cs_f = flip ? cs_s : flt_q;

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      flt_q  <= 1'b1;
      fcnt_q <= '0;
    end else if (cs_s == flt_q || flip) begin
      flt_q  <= cs_s;
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + 1'b1;
    end
  end
`else
  assign cs_f = cs_s;
`endif

  logic [WW-1:0] warm_q;
  logic          warm_done;
  assign warm_done = (warm_q == WW'(WARM));

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset)         warm_q <= '0;
    else if (!warm_done) warm_q <= warm_q + 1'b1;
  end

  tpi_state_e state_q, state_d;
  logic [2:0] lat_rs_q;
  logic [7:0] lat_d_q;
  logic       lat_we_q;
  logic       commit, addr_bad, wr_try, push, pop, full, empty, ovr_set, overrun_q;
  tpi_wr_t    head;

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) state_q <= ARM;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARM:     if (warm_done && cs_f) state_d = IDLE;
      IDLE:    if (!cs_f) state_d = ACCESS;
      ACCESS:  if (cs_f) state_d = lat_we_q ? IDLE : COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = ARM;
    endcase
  end

  always_comb begin
    rd_active = (state_q == ACCESS) && we_s;
    rd_addr   = rd_active ? rs_s : 3'd0;
    commit    = (state_q == COMMIT);
    addr_bad  = lat_rs_q > RS_MAX;
    bad_addr  = commit && addr_bad;
    wr_try    = commit && !addr_bad;
    push      = wr_try && (!full || pop);
    ovr_set   = wr_try && full && !pop;
  end

  // Latch on the raw synchronised _cs so filter delay never captures post-access values.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      lat_rs_q <= '0;
      lat_d_q  <= '0;
      lat_we_q <= 1'b1;
    end else if ((state_q == IDLE || state_q == ACCESS) && !cs_s) begin
      lat_rs_q <= rs_s;
      lat_d_q  <= d_s;
      lat_we_q <= we_s;
    end
  end

  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset)      overrun_q <= 1'b0;
    else if (ovr_set) overrun_q <= 1'b1;
    else if (ovr_clr) overrun_q <= 1'b0;
  end

  assign overrun  = overrun_q;
  assign wr_valid = ~empty;
  assign pop      = wr_valid & wr_ready;
  assign wr_addr  = head.addr;
  assign wr_data  = head.data;

  tpi_post_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    ._reset  (_reset),
    .push_i  (push),
    .din_i   ('{addr: lat_rs_q, data: lat_d_q}),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule

// File: tb/tb_tpi_bus_sync.sv
// Self-checking bench for tpi_bus_sync: vector table plus hand-written reset/overrun/filter sequences.
module tb_tpi_bus_sync;

  localparam int DEPTH = 2;
  localparam int SYNC  = 2;
  localparam int FLEN  = 3;
`ifdef TPI_BUS_FILTER_EN
  localparam int FLAT = FLEN - 1;
`else
  localparam int FLAT = 0;
`endif
  localparam int LAT   = SYNC + 2 + FLAT;
  localparam int RDCHK = 3 + FLAT;

  logic       clk = 1'b0, _reset = 1'b0, _cs = 1'b1, _write = 1'b1;
  logic       wr_ready = 1'b0, ovr_clr = 1'b0;
  logic [2:0] rs = '0;
  logic [7:0] data_in = '0;
  logic       wr_valid, rd_active, overrun, bad_addr;
  logic [2:0] wr_addr, rd_addr;
  logic [7:0] wr_data;

  always #5 clk = ~clk;

  tpi_bus_sync #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .FILTER_LEN(FLEN)) dut (
    .clk(clk), ._reset(_reset), ._cs(_cs), ._write(_write), .rs(rs), .data_in(data_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_active(rd_active), .rd_addr(rd_addr), .overrun(overrun), .bad_addr(bad_addr),
    .ovr_clr(ovr_clr)
  );

  typedef struct {
    logic [2:0] rs;
    logic [7:0] d;
    logic       we;
    int         hold;
    int         post;
    int         bad;
  } vec_t;

  typedef struct packed {
    logic [2:0] a;
    logic [7:0] d;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, rise_cyc = 0, lat_meas = -1, nvalid = 0, nbad = 0;
  bit   lat_arm = 0, prev_valid = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (wr_valid) nvalid++;
      if (bad_addr) nbad++;
      if (lat_arm && wr_valid && !prev_valid) begin
        lat_meas = cyc - rise_cyc;
        lat_arm  = 0;
      end
      prev_valid = wr_valid;
      if (wr_valid && wr_ready) begin
        if (sb.size() == 0) chk("pop_with_empty_scoreboard", int'(wr_valid), 0);
        else begin
          e = sb.pop_front();
          chk("pop_addr", int'(wr_addr), int'(e.a));
          chk("pop_data", int'(wr_data), int'(e.d));
        end
      end
    end
  endtask

  task automatic raw_access(input logic [2:0] r, input logic [7:0] d, input int hold);
    _cs = 1'b0; _write = 1'b0; rs = r; data_in = d;
    step(hold);
    _cs = 1'b1;
    step(1);
    _write = 1'b1;
    step(LAT + 4);
  endtask

  task automatic access(input vec_t v, input bit chk_lat);
    int   nv0, nb0;
    exp_t e;
    nv0 = nvalid; nb0 = nbad;
    if (v.post != 0) begin
      e.a = v.rs; e.d = v.d;
      sb.push_back(e);
    end
    _cs = 1'b0; _write = v.we; rs = v.rs; data_in = v.d;
    for (int i = 1; i <= v.hold; i++) begin
      step(1);
      if (i == RDCHK) begin
        @(negedge clk);
        chk("rd_active_during", int'(rd_active), int'(v.we));
        chk("rd_addr_during", int'(rd_addr), v.we ? int'(v.rs) : 0);
      end
    end
    _cs = 1'b1;
    rise_cyc = cyc;
    lat_meas = -1;
    lat_arm  = chk_lat;
    step(1);
    _write = 1'b1;
    step(LAT + 4);
    lat_arm = 0;
    @(negedge clk);
    chk("rd_active_after", int'(rd_active), 0);
    chk("bad_pulses", nbad - nb0, v.bad);
    chk("valid_cycles", nvalid - nv0, v.post);
    if (chk_lat && v.post != 0) chk("write_latency", lat_meas, LAT);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    vec_t v;
    int   nv0;
    vecs[0] = '{3'd3, 8'hFF, 1'b0, 10, 1, 0};
    vecs[1] = '{3'd0, 8'h00, 1'b0,  4, 1, 0};
    vecs[2] = '{3'd5, 8'hA5, 1'b0,  6, 1, 0};
    vecs[3] = '{3'd6, 8'hAA, 1'b0,  5, 0, 1};
    vecs[4] = '{3'd7, 8'h55, 1'b0,  5, 0, 1};
    vecs[5] = '{3'd5, 8'h3C, 1'b1,  8, 0, 0};
    vecs[6] = '{3'd2, 8'hC3, 1'b0,  6, 1, 0};

    fork monitor(); join_none

    // Reset state
    step(3);
    @(negedge clk);
    chk("rst_wr_valid", int'(wr_valid), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    chk("rst_rd_active", int'(rd_active), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_bad_addr", int'(bad_addr), 0);
    _reset = 1'b1;
    wr_ready = 1'b1;
    step(SYNC + FLEN + 6);

    for (int i = 0; i < 7; i++) access(vecs[i], 1'b1);

    // Overrun: three writes into a DEPTH=2 buffer with no consumer
    wr_ready = 1'b0;
    v = '{3'd0, 8'h11, 1'b0, 4, 1, 0};
    begin exp_t e; e.a = 3'd0; e.d = 8'h11; sb.push_back(e); e.a = 3'd1; e.d = 8'h22; sb.push_back(e); end
    raw_access(3'd0, 8'h11, 4);
    raw_access(3'd1, 8'h22, 4);
    raw_access(3'd2, 8'h33, 4);
    @(negedge clk);
    chk("ovr_set", int'(overrun), 1);
    chk("ovr_head_valid", int'(wr_valid), 1);
    chk("ovr_head_addr", int'(wr_addr), 0);
    chk("ovr_head_data", int'(wr_data), 8'h11);
    step(3);
    @(negedge clk);
    chk("head_stable_data", int'(wr_data), 8'h11);
    step(1);
    wr_ready = 1'b1;
    step(4);
    @(negedge clk);
    chk("ovr_drained", sb.size(), 0);
    chk("ovr_empty", int'(wr_valid), 0);
    chk("ovr_sticky", int'(overrun), 1);
    step(1);
    ovr_clr = 1'b1;
    step(1);
    ovr_clr = 1'b0;
    @(negedge clk);
    chk("ovr_cleared", int'(overrun), 0);
    step(1);

    // Reset mid-write: nothing may be emitted
    nv0 = nvalid;
    _cs = 1'b0; _write = 1'b0; rs = 3'd1; data_in = 8'h77;
    step(6);
    _reset = 1'b0;
    step(1);
    @(negedge clk);
    chk("midrst_wr_valid", int'(wr_valid), 0);
    step(2);
    _reset = 1'b1;
    step(5);
    _cs = 1'b1;
    step(LAT + 6);
    _write = 1'b1;
    step(2);
    chk("midrst_no_post", nvalid - nv0, 0);
    v = '{3'd0, 8'h5A, 1'b0, 6, 1, 0};
    access(v, 1'b1);

`ifdef TPI_BUS_FILTER_EN
    // Short _cs glitch must not create an access
    begin
      int nb0;
      nv0 = nvalid; nb0 = nbad;
      _cs = 1'b0; _write = 1'b0; rs = 3'd2; data_in = 8'h99;
      step(2);
      _cs = 1'b1;
      step(1);
      _write = 1'b1;
      step(LAT + 6);
      chk("glitch_no_post", nvalid - nv0, 0);
      chk("glitch_no_bad", nbad - nb0, 0);
    end
    v = '{3'd4, 8'h66, 1'b0, 6, 1, 0};
    access(v, 1'b1);
`endif

    step(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
